// File: rtl/axi_10g_ethernet_0_tx_arb.sv
// ---------------------------------------------------------------------------
// axi_10g_ethernet_0_tx_arb
//
// Packet-atomic arbiter merging two transmit AXI-Stream sources into the
// single registered 64-bit stream that feeds the 10G Ethernet MAC.
//   - RAM source  (tx_ram_*)  : protocol-generated frames (ARP/ICMP replies).
//   - FIFO source (tx_fifo_*) : user payload frames.
//   - tx_axis_*               : registered output stream to the MAC.
//   - tx_ram_frames / tx_fifo_frames : wrapping counts of frames whose last
//     beat has been accepted from each source.
//   - aclk / aresetn          : single clock, asynchronous active-low reset.
//
// Handshake: a beat moves on any interface in a cycle where tvalid && tready
// are both high; tvalid never depends on tready, and the output stream holds
// tdata/tkeep/tlast stable while tvalid is high and tready is low.
//
// Optional feature: define TX_ARB_ROUND_ROBIN_EN to replace fixed RAM
// priority with round-robin between simultaneous requesters. Without it the
// RAM source always wins a tie in IDLE.
// ---------------------------------------------------------------------------
module axi_10g_ethernet_0_tx_arb #(
    parameter int  DATA_W = 64,
    parameter int  CNT_W  = 16,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] tx_ram_tdata,
    input  logic [KEEP_W-1:0] tx_ram_tkeep,
    input  logic              tx_ram_tvalid,
    input  logic              tx_ram_tlast,
    output logic              tx_ram_tready,
    input  logic [DATA_W-1:0] tx_fifo_tdata,
    input  logic [KEEP_W-1:0] tx_fifo_tkeep,
    input  logic              tx_fifo_tvalid,
    input  logic              tx_fifo_tlast,
    output logic              tx_fifo_tready,
    output logic [DATA_W-1:0] tx_axis_tdata,
    output logic [KEEP_W-1:0] tx_axis_tkeep,
    output logic              tx_axis_tvalid,
    output logic              tx_axis_tlast,
    input  logic              tx_axis_tready,
    output logic [CNT_W-1:0]  tx_ram_frames,
    output logic [CNT_W-1:0]  tx_fifo_frames
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND_RAM  = 2'd1;
    localparam logic [1:0] ST_SEND_FIFO = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic out_free;
    logic ram_rdy, fifo_rdy;
    logic ram_acc, fifo_acc;
    logic pick_ram;

`ifdef TX_ARB_ROUND_ROBIN_EN
    localparam logic GRANT_RAM  = 1'b0;
    localparam logic GRANT_FIFO = 1'b1;

    logic last_grant_q, last_grant_d;

    // On a tie the source that was not granted last time wins.
    assign pick_ram = tx_ram_tvalid && !(tx_fifo_tvalid && (last_grant_q == GRANT_RAM));
`else
    assign pick_ram = tx_ram_tvalid;
`endif

    // The output register can take a new beat when it is empty or draining.
    assign out_free = !tvalid_q || tx_axis_tready;
    assign ram_rdy  = (state_q == ST_SEND_RAM)  && out_free;
    assign fifo_rdy = (state_q == ST_SEND_FIFO) && out_free;
    assign ram_acc  = ram_rdy  && tx_ram_tvalid;
    assign fifo_acc = fifo_rdy && tx_fifo_tvalid;

    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        ram_cnt_d  = ram_cnt_q;
        fifo_cnt_d = fifo_cnt_q;

        // A consumed output beat empties the register unless refilled below.
        if (tvalid_q && tx_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_ram) begin
                    state_d = ST_SEND_RAM;
                end else if (tx_fifo_tvalid) begin
                    state_d = ST_SEND_FIFO;
                end
            end
            ST_SEND_RAM: begin
                if (ram_acc) begin
                    tdata_d  = tx_ram_tdata;
                    tkeep_d  = tx_ram_tkeep;
                    tlast_d  = tx_ram_tlast;
                    tvalid_d = 1'b1;
                    if (tx_ram_tlast) begin
                        state_d   = ST_IDLE;
                        ram_cnt_d = ram_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SEND_FIFO: begin
                if (fifo_acc) begin
                    tdata_d  = tx_fifo_tdata;
                    tkeep_d  = tx_fifo_tkeep;
                    tlast_d  = tx_fifo_tlast;
                    tvalid_d = 1'b1;
                    if (tx_fifo_tlast) begin
                        state_d    = ST_IDLE;
                        fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef TX_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == ST_IDLE && state_d == ST_SEND_RAM) begin
            last_grant_d = GRANT_RAM;
        end else if (state_q == ST_IDLE && state_d == ST_SEND_FIFO) begin
            last_grant_d = GRANT_FIFO;
        end
    end

    // Resets to FIFO so the first tie goes to the RAM source.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant_q <= GRANT_FIFO;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            ram_cnt_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            ram_cnt_q  <= ram_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign tx_ram_tready  = ram_rdy;
    assign tx_fifo_tready = fifo_rdy;
    assign tx_axis_tdata  = tdata_q;
    assign tx_axis_tkeep  = tkeep_q;
    assign tx_axis_tvalid = tvalid_q;
    assign tx_axis_tlast  = tlast_q;
    assign tx_ram_frames  = ram_cnt_q;
    assign tx_fifo_frames = fifo_cnt_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_10g_ethernet_0_tx_arb
//
// Self-checking bench for the two-source TX arbiter. Expected output is kept
// as per-source queues of frames; every output frame must be a complete,
// in-order copy of the head frame of one source. Arbitration order, latency,
// stall behaviour, reset and counter wrap are checked against the model.
// The counters are instantiated narrower than default so wrap is reachable.
// ---------------------------------------------------------------------------
module tb_axi_10g_ethernet_0_tx_arb;

  localparam int CNT_W    = 10;
  localparam int SRC_RAM  = 0;
  localparam int SRC_FIFO = 1;
`ifdef TX_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [63:0]      tx_ram_tdata = '0;
  logic [7:0]       tx_ram_tkeep = '0;
  logic             tx_ram_tvalid = 1'b0;
  logic             tx_ram_tlast = 1'b0;
  logic             tx_ram_tready;
  logic [63:0]      tx_fifo_tdata = '0;
  logic [7:0]       tx_fifo_tkeep = '0;
  logic             tx_fifo_tvalid = 1'b0;
  logic             tx_fifo_tlast = 1'b0;
  logic             tx_fifo_tready;
  logic [63:0]      tx_axis_tdata;
  logic [7:0]       tx_axis_tkeep;
  logic             tx_axis_tvalid;
  logic             tx_axis_tlast;
  logic             tx_axis_tready = 1'b1;
  logic [CNT_W-1:0] tx_ram_frames;
  logic [CNT_W-1:0] tx_fifo_frames;

  axi_10g_ethernet_0_tx_arb #(.DATA_W(64), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .tx_ram_tdata(tx_ram_tdata), .tx_ram_tkeep(tx_ram_tkeep),
    .tx_ram_tvalid(tx_ram_tvalid), .tx_ram_tlast(tx_ram_tlast),
    .tx_ram_tready(tx_ram_tready),
    .tx_fifo_tdata(tx_fifo_tdata), .tx_fifo_tkeep(tx_fifo_tkeep),
    .tx_fifo_tvalid(tx_fifo_tvalid), .tx_fifo_tlast(tx_fifo_tlast),
    .tx_fifo_tready(tx_fifo_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tready(tx_axis_tready),
    .tx_ram_frames(tx_ram_frames), .tx_fifo_frames(tx_fifo_frames)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  beat_t ram_q[$];
  beat_t fifo_q[$];
  int    order_q[$];
  int    exp_frames[2];
  int    model_last = SRC_FIFO;
  int    frame_id = 0;
  int    tests_run = 0;
  int    tests_failed = 0;
  int    rdy_mode = 0;
  logic  rdy_pat[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- MAC ready driver ----------------
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      1: tx_axis_tready = ($urandom_range(0, 3) != 0);
      2: tx_axis_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      default: tx_axis_tready = 1'b1;
    endcase
  end

  // ---------------- output monitor ----------------
  int    cur_src = -1;
  logic  prev_v = 1'b0;
  logic  prev_r = 1'b0;
  beat_t prev_b = '0;

  always @(negedge aclk) begin
    beat_t obs;
    obs = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast};
    if (!aresetn) begin
      cur_src = -1;
      prev_v  = 1'b0;
      prev_r  = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_stable", {tx_axis_tvalid, obs}, {1'b1, prev_b});
      end
      if (tx_axis_tvalid && tx_axis_tready) begin
        if (cur_src < 0) begin
          if (ram_q.size() > 0 && ram_q[0] == obs) cur_src = SRC_RAM;
          else if (fifo_q.size() > 0 && fifo_q[0] == obs) cur_src = SRC_FIFO;
          else if (ram_q.size() > 0) cur_src = SRC_RAM;
          else if (fifo_q.size() > 0) cur_src = SRC_FIFO;
          if (cur_src >= 0) order_q.push_back(cur_src);
        end
        if (cur_src == SRC_RAM && ram_q.size() > 0) begin
          check("ram_beat", obs, ram_q.pop_front());
        end else if (cur_src == SRC_FIFO && fifo_q.size() > 0) begin
          check("fifo_beat", obs, fifo_q.pop_front());
        end else begin
          check("beat_expected", 128'(ram_q.size() + fifo_q.size()), 128'd1);
        end
        if (obs.last) cur_src = -1;
      end
      prev_v = tx_axis_tvalid;
      prev_r = tx_axis_tready;
      prev_b = obs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_src(input int src, input beat_t b, input logic v);
    if (src == SRC_RAM) begin
      tx_ram_tdata = b.data; tx_ram_tkeep = b.keep; tx_ram_tlast = b.last; tx_ram_tvalid = v;
    end else begin
      tx_fifo_tdata = b.data; tx_fifo_tkeep = b.keep; tx_fifo_tlast = b.last; tx_fifo_tvalid = v;
    end
  endtask

  function automatic logic src_ready(input int src);
    return (src == SRC_RAM) ? tx_ram_tready : tx_fifo_tready;
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_frame(input int src, input int n, input int gap_at,
                            input int gap_len, input int idle_before);
    beat_t f[$];
    beat_t b;
    int    fid;
    int    wait_cnt;
    fid = frame_id;
    frame_id++;
    for (int i = 0; i < n; i++) begin
      b.data = {8'(src + 8'hA0), 16'(fid), 8'(i), 32'($urandom)};
      b.last = (i == n - 1);
      b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
      f.push_back(b);
      if (src == SRC_RAM) ram_q.push_back(b);
      else fifo_q.push_back(b);
    end
    repeat (idle_before) begin @(posedge aclk); #1; end
    for (int i = 0; i < n; i++) begin
      drive_src(src, f[i], 1'b1);
      wait_cnt = 0;
      @(negedge aclk);
      while (!src_ready(src) && wait_cnt < 2000) begin
        @(negedge aclk);
        wait_cnt++;
      end
      if (wait_cnt >= 2000) begin
        check("ready_timeout", 128'(wait_cnt), 128'd0);
        drive_src(src, f[i], 1'b0);
        return;
      end
      @(posedge aclk); #1;
      if (i == gap_at && gap_len > 0) begin
        drive_src(src, f[i], 1'b0);
        repeat (gap_len) begin @(posedge aclk); #1; end
      end
    end
    drive_src(src, f[n-1], 1'b0);
    exp_frames[src]++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge aclk);
    while ((tx_axis_tvalid || ram_q.size() > 0 || fifo_q.size() > 0) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_drain"}, {tx_axis_tvalid, 32'(ram_q.size()), 32'(fifo_q.size())}, 128'd0);
    @(posedge aclk); #1;
  endtask

  // Directed 3-beat RAM frame with cycle-exact latency checks (tready held 1).
  task automatic latency_frame(input string tag);
    beat_t f[3];
    f[0] = {64'h1111_1111_1111_1111, 8'hFF, 1'b0};
    f[1] = {64'h2222_2222_2222_2222, 8'hFF, 1'b0};
    f[2] = {64'h3333_3333_3333_3333, 8'h0F, 1'b1};
    for (int i = 0; i < 3; i++) ram_q.push_back(f[i]);
    drive_src(SRC_RAM, f[0], 1'b1);
    @(negedge aclk);
    check({tag, "_c0_rdy"}, tx_ram_tready, 1'b0);
    @(negedge aclk);
    check({tag, "_c1_rdy"}, tx_ram_tready, 1'b1);
    check({tag, "_c1_out"}, tx_axis_tvalid, 1'b0);
    @(posedge aclk); #1;
    drive_src(SRC_RAM, f[1], 1'b1);
    @(negedge aclk);
    check({tag, "_c2_out"}, {tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}, {1'b1, f[0]});
    @(posedge aclk); #1;
    drive_src(SRC_RAM, f[2], 1'b1);
    @(negedge aclk);
    check({tag, "_c3_out"}, {tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}, {1'b1, f[1]});
    @(posedge aclk); #1;
    drive_src(SRC_RAM, f[2], 1'b0);
    exp_frames[SRC_RAM]++;
    model_last = SRC_RAM;
    @(negedge aclk);
    check({tag, "_c4_out"}, {tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}, {1'b1, f[2]});
    check({tag, "_c4_rdy"}, tx_ram_tready, 1'b0);
    check({tag, "_ram_frames"}, tx_ram_frames, 128'(exp_frames[SRC_RAM] % (1 << CNT_W)));
    @(posedge aclk); #1;
    @(negedge aclk);
    check({tag, "_c5_empty"}, tx_axis_tvalid, 1'b0);
    @(posedge aclk); #1;
  endtask

  // Both sources request in the same IDLE cycle with 2-beat frames.
  task automatic contention(input string tag);
    int winner, loser, o0, o1;
    order_q.delete();
    fork
      send_frame(SRC_RAM, 2, -1, 0, 0);
      send_frame(SRC_FIFO, 2, -1, 0, 0);
    join
    drain(tag);
    winner = (RR_EN && model_last == SRC_RAM) ? SRC_FIFO : SRC_RAM;
    loser = 1 - winner;
    model_last = loser;
    o0 = (order_q.size() > 0) ? order_q[0] : -1;
    o1 = (order_q.size() > 1) ? order_q[1] : -1;
    check({tag, "_nframes"}, 128'(order_q.size()), 128'd2);
    check({tag, "_first"}, 128'(o0), 128'(winner));
    check({tag, "_second"}, 128'(o1), 128'(loser));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_ram_frames"}, tx_ram_frames, 128'(exp_frames[SRC_RAM] % (1 << CNT_W)));
    check({tag, "_fifo_frames"}, tx_fifo_frames, 128'(exp_frames[SRC_FIFO] % (1 << CNT_W)));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    beat_t f[4];
    int    o0, o1;
    exp_frames[0] = 0;
    exp_frames[1] = 0;

    // Reset
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs",
          {tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast,
           tx_ram_tready, tx_fifo_tready, tx_ram_frames, tx_fifo_frames}, 128'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Contention straight out of reset, twice
    contention("cont1");
    contention("cont2");

    // Single RAM frame timing, then contention right after a RAM grant
    latency_frame("single");
    contention("cont3");
    check_counters("after_cont");

    // MAC stalls during a 4-beat FIFO frame
    order_q.delete();
    rdy_mode = 2;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    send_frame(SRC_FIFO, 4, -1, 0, 0);
    drain("stall");
    rdy_mode = 0;
    check("stall_nframes", 128'(order_q.size()), 128'd1);
    check_counters("stall");

    // FIFO pauses mid-frame while RAM is waiting
    order_q.delete();
    fork
      send_frame(SRC_FIFO, 4, 1, 3, 0);
      begin @(posedge aclk); #1; send_frame(SRC_RAM, 2, -1, 0, 0); end
      begin
        repeat (3) @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
          @(negedge aclk);
          check("gap_ram_blocked", {tx_ram_tready, tx_fifo_tvalid}, 2'b00);
        end
      end
    join
    drain("gap");
    model_last = SRC_RAM;
    o0 = (order_q.size() > 0) ? order_q[0] : -1;
    o1 = (order_q.size() > 1) ? order_q[1] : -1;
    check("gap_first", 128'(o0), 128'(SRC_FIFO));
    check("gap_second", 128'(o1), 128'(SRC_RAM));

    // Reset in the middle of a 4-beat RAM frame
    for (int i = 0; i < 4; i++) begin
      f[i] = {64'hDEAD_0000_0000_0000 | 64'(i), 8'hFF, 1'(i == 3)};
      ram_q.push_back(f[i]);
    end
    drive_src(SRC_RAM, f[0], 1'b1);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    drive_src(SRC_RAM, f[1], 1'b1);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("midreset_outputs",
          {tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast,
           tx_ram_tready, tx_fifo_tready, tx_ram_frames, tx_fifo_frames}, 128'd0);
    drive_src(SRC_RAM, f[1], 1'b0);
    ram_q.delete();
    fifo_q.delete();
    exp_frames[0] = 0;
    exp_frames[1] = 0;
    model_last = SRC_FIFO;
    @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    latency_frame("post_reset");

    // FIFO frame counter wrap
    for (int i = 0; i < (1 << CNT_W) - 1; i++) send_frame(SRC_FIFO, 1, -1, 0, 0);
    drain("wrap_fill");
    check("wrap_full", tx_fifo_frames, 128'((1 << CNT_W) - 1));
    send_frame(SRC_FIFO, 1, -1, 0, 0);
    drain("wrap_roll");
    check("wrap_zero", tx_fifo_frames, 128'd0);
    check_counters("wrap");

    // Randomized traffic from both sources with random MAC back-pressure
    rdy_mode = 1;
    fork
      for (int i = 0; i < 25; i++)
        send_frame(SRC_RAM, $urandom_range(1, 6), $urandom_range(0, 5),
                   $urandom_range(0, 2), $urandom_range(0, 3));
      for (int i = 0; i < 25; i++)
        send_frame(SRC_FIFO, $urandom_range(1, 6), $urandom_range(0, 5),
                   $urandom_range(0, 2), $urandom_range(0, 3));
    join
    drain("random");
    rdy_mode = 0;
    check_counters("random");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_10g_ethernet_0_tx_arb.md
# axi_10g_ethernet_0_tx_arb

Packet-atomic arbiter that merges two transmit AXI-Stream sources into the single 64-bit TX stream feeding the 10G Ethernet MAC. The RAM source carries protocol-generated frames (ARP/ICMP replies) and the FIFO source carries user payload frames. The block is the transmit-side counterpart of the RX path mux: the RX mux fans the MAC stream out to the user, and this block fans two user streams into the MAC. It never interleaves beats of different frames, registers the output, and counts the frames forwarded per source.

## Interface
Parameters:
- DATA_W, 64, stream data width; fixed at 64, and KEEP_W = DATA_W/8.
- CNT_W, 16, width of the per-source frame counters.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  reset; **asynchronous, active-low**.
- tx_ram_tdata  in  64  RAM source data.
- tx_ram_tkeep  in  8  RAM source byte enables.
- tx_ram_tvalid  in  1  RAM source valid.
- tx_ram_tlast  in  1  RAM source end of frame.
- tx_ram_tready  out  1  RAM source ready.
- tx_fifo_tdata / tx_fifo_tkeep / tx_fifo_tvalid / tx_fifo_tlast  in  64/8/1/1  FIFO source, same meaning as the RAM source.
- tx_fifo_tready  out  1  FIFO source ready.
- tx_axis_tdata  out  64  data to the MAC.
- tx_axis_tkeep  out  8  byte enables to the MAC.
- tx_axis_tvalid  out  1  valid to the MAC.
- tx_axis_tlast  out  1  end of frame to the MAC.
- tx_axis_tready  in  1  MAC ready.
- tx_ram_frames  out  CNT_W  count of RAM frames whose last beat has been accepted from the source.
- tx_fifo_frames  out  CNT_W  count of FIFO frames whose last beat has been accepted from the source.

## Operation
- The FSM has three states: IDLE, SEND_RAM and SEND_FIFO.
- IDLE:
  - Both source treadys are 0.
  - If tx_ram_tvalid is 1, the next state is SEND_RAM.
  - Otherwise, if tx_fifo_tvalid is 1, the next state is SEND_FIFO.
  - Otherwise the FSM stays in IDLE.
- SEND_x:
  - The granted source's tready = !tx_axis_tvalid || tx_axis_tready.
  - The other source's tready is 0.
  - A source beat is accepted when that source's tvalid && tready.
  - An accepted beat loads tdata/tkeep/tlast into the output register and sets tx_axis_tvalid to 1.
  - An accepted beat with tlast = 1 returns the FSM to IDLE and increments the matching frame counter.
- Output register:
  - When tx_axis_tvalid && tx_axis_tready and no new beat is accepted in the same cycle, tx_axis_tvalid clears to 0.
  - While tx_axis_tvalid = 1 and tx_axis_tready = 0, tx_axis_tdata/tkeep/tlast are held stable.
- tkeep and tdata pass through unmodified. Upstream guarantees tkeep = 8'hFF on non-last beats. The block does not check this.
- The frame counters wrap from 2^CNT_W−1 to 0 and are not saturating.
- A source that deasserts tvalid mid-frame keeps the grant. The FSM stays in SEND_x until that source's tlast beat is accepted.
- Reset behaviour (reset mid-frame included):
  - Every output is 0: all tx_axis_* signals, both source treadys and both counters.
  - The FSM goes to IDLE.
  - A partially sent frame is truncated. Discarding a truncated frame is the MAC/upstream's responsibility.

## Timing
- Arbitration takes one cycle. A source's tvalid rising in IDLE at cycle 0 gives tready = 1 at cycle 1.
- The first beat is accepted at cycle 1 and appears on tx_axis at cycle 2. Source-to-MAC latency is 1 cycle per beat once the source is granted.
- Throughput within a frame is one beat per cycle while tx_axis_tready = 1.
- There is exactly one idle source-acceptance cycle between frames, which is the IDLE state. The output may still be draining during that cycle.
- When both sources assert tvalid in the same IDLE cycle, the winner is the RAM source by default (see Configuration).
- An output beat is transferred only when tx_axis_tvalid && tx_axis_tready. No beat is ever dropped or duplicated under any tready pattern.

## Configuration
- Macro: TX_ARB_ROUND_ROBIN_EN.
- Without TX_ARB_ROUND_ROBIN_EN, arbitration is fixed priority. The RAM source always wins simultaneous requests in IDLE, and the FIFO source can be starved.
- With TX_ARB_ROUND_ROBIN_EN, a 1-bit last_grant register is added; it resets to FIFO.
  - On simultaneous requests in IDLE, the source not named in last_grant wins.
  - last_grant updates on every transition into SEND_x.
  - A single requester is granted immediately, as in fixed priority.

## Test plan
- Single RAM frame of 3 beats (data 0x11…, 0x22…, 0x33…, last tkeep 8'h0F) with tx_axis_tready = 1 -> output matches on cycles 2–4, tlast is 1 only on beat 3, and tx_ram_frames = 1.
- RAM and FIFO both valid at cycle 0, each sending a 2-beat frame:
  - Macro undefined -> RAM frame is output first, then the FIFO frame, with no interleaving.
  - Macro defined with two back-to-back contention rounds -> grants alternate FIFO/RAM starting with RAM (last_grant resets to FIFO).
- tx_axis_tready toggled 1,0,0,1,0,1 during a 4-beat FIFO frame -> every beat appears exactly once in order, and tdata is stable while stalled.
- FIFO source drops tvalid for 3 cycles mid-frame while RAM is valid -> the grant stays with FIFO, RAM tready remains 0 until the FIFO tlast is accepted, and then the RAM frame is sent.
- aresetn asserted mid-frame on beat 2 of 4 -> all outputs are 0 asynchronously, and after release the next RAM request is granted from IDLE with 1-cycle arbitration.
- Preset tx_fifo_frames to 16'hFFFF by sending 65535 1-beat frames, then send 1 more -> counter wraps to 0.
